// File: rtl/collision_ci_ctrl.sv
// Purpose: custom-instruction front end that loads a message buffer, launches hash/search engines and latches the first collision.
// Latency: every accepted instruction completes with a one-cycle done pulse on the next clock edge.
// Backpressure: none; an instruction is accepted on any edge with start=1 and clk_en=1, and engine monitoring never stalls.
//
// Ports:
//   clk, reset (async active-low)              - clock and reset
//   clk_en, start, dataa, datab, n             - instruction request, operands and opcode
//   done, result                               - completion pulse and held result
//   eng_msg, eng_target                        - message buffer (word 0 in MSBs) and search target
//   eng_start, eng_abort                       - one-cycle pulses to the engines
//   eng_digest, eng_hit, eng_counter           - per-engine digest/hit pulses and counter values
module collision_ci_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int MSG_WORDS = 16,
  parameter int NUM_ENG   = 4,
  parameter int CNT_W     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           start,
  input  logic [WORD_SIZE-1:0]           dataa,
  input  logic [WORD_SIZE-1:0]           datab,
  input  logic [2:0]                     n,
  output logic                           done,
  output logic [WORD_SIZE-1:0]           result,
  output logic [MSG_WORDS*WORD_SIZE-1:0] eng_msg,
  output logic [WORD_SIZE-1:0]           eng_target,
  output logic [NUM_ENG-1:0]             eng_start,
  output logic [NUM_ENG-1:0]             eng_abort,
  input  logic [NUM_ENG-1:0]             eng_digest,
  input  logic [NUM_ENG-1:0]             eng_hit,
  input  logic [NUM_ENG*CNT_W-1:0]       eng_counter
);

  localparam int PTR_W = (MSG_WORDS > 2) ? $clog2(MSG_WORDS) : 1;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_SEARCH  = 3'd1;
  localparam logic [2:0] OP_RESULT  = 3'd2;
  localparam logic [2:0] OP_STATUS  = 3'd3;
  localparam logic [2:0] OP_DIGESTS = 3'd4;
  localparam logic [2:0] OP_ABORT   = 3'd5;
  localparam logic [2:0] OP_RSTPTR  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FOUND} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr, ptr_hi, ptr_nxt;
  logic [WORD_SIZE-1:0] msg [MSG_WORDS];
  logic [WORD_SIZE-1:0] dig_cnt, dig_nxt;
  logic [WORD_SIZE:0]   dig_sum;
  logic [3:0]           win_idx, hit_idx;
  logic [CNT_W-1:0]     win_cnt, hit_cnt;
  logic [NUM_ENG-1:0]   abort_mask;
  logic [WORD_SIZE-1:0] res_d, status;
  logic                 accept, busy, do_load, do_search, do_abort, hit_take;

  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg
    assign eng_msg[(MSG_WORDS-1-g)*WORD_SIZE +: WORD_SIZE] = msg[g];
  end

  always_comb begin
    accept    = start && clk_en;
    busy      = (state_q == S_SEARCH);
    do_load   = accept && (n == OP_LOAD) && !busy;
    do_search = accept && (n == OP_SEARCH) && !busy;
    do_abort  = accept && (n == OP_ABORT);
    // An abort on the same edge as a hit wins and discards the hit.
    hit_take  = busy && (|eng_hit) && !do_abort;

    ptr_hi  = wr_ptr + PTR_W'(1);
    ptr_nxt = (wr_ptr == PTR_W'(MSG_WORDS-2)) ? '0 : wr_ptr + PTR_W'(2);

    // Descending scan so the lowest asserted engine is the last one written.
    hit_idx = '0;
    hit_cnt = '0;
    for (int i = NUM_ENG-1; i >= 0; i--) begin
      if (eng_hit[i]) begin
        hit_idx = 4'(i);
        hit_cnt = eng_counter[i*CNT_W +: CNT_W];
      end
    end
    for (int i = 0; i < NUM_ENG; i++) begin
      abort_mask[i] = (4'(i) != hit_idx);
    end

    // One spare bit catches overflow so the count saturates.
    dig_sum = {1'b0, dig_cnt};
    for (int i = 0; i < NUM_ENG; i++) begin
      dig_sum = dig_sum + (WORD_SIZE+1)'(eng_digest[i]);
    end
    dig_nxt = dig_sum[WORD_SIZE] ? '1 : dig_sum[WORD_SIZE-1:0];

    status    = '0;
    status[0] = (state_q == S_FOUND);
    status[1] = busy;
    if (state_q == S_FOUND) status[15:8] = {4'b0, win_idx};

    case (n)
      OP_LOAD:    res_d = busy ? '1 : WORD_SIZE'(ptr_nxt);
      OP_SEARCH:  res_d = busy ? '1 : '0;
      OP_RESULT:  res_d = WORD_SIZE'(win_cnt);
      OP_STATUS:  res_d = status;
      OP_DIGESTS: res_d = dig_cnt;
      default:    res_d = '0;
    endcase

    state_d = state_q;
    if (hit_take)  state_d = S_FOUND;
    if (do_search) state_d = S_SEARCH;
    if (do_abort)  state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done       <= 1'b0;
      result     <= '0;
      wr_ptr     <= '0;
      eng_target <= '0;
      dig_cnt    <= '0;
      win_idx    <= '0;
      win_cnt    <= '0;
      eng_start  <= '0;
      eng_abort  <= '0;
      for (int i = 0; i < MSG_WORDS; i++) msg[i] <= '0;
    end else begin
      done      <= accept;
      eng_start <= do_search ? '1 : '0;
      eng_abort <= do_abort ? '1 : (hit_take ? abort_mask : '0);
      if (accept) result <= res_d;
      if (do_load) begin
        msg[wr_ptr] <= dataa;
        msg[ptr_hi] <= datab;
        wr_ptr      <= ptr_nxt;
      end
      if (accept && (n == OP_RSTPTR)) wr_ptr <= '0;
      if (do_search) begin
        eng_target <= dataa;
        dig_cnt    <= '0;
        win_idx    <= '0;
        win_cnt    <= '0;
      end else if (busy) begin
        dig_cnt <= dig_nxt;
      end
      if (hit_take) begin
        win_idx <= hit_idx;
        win_cnt <= hit_cnt;
      end
    end
  end

endmodule

// File: tb/tb_collision_ci_ctrl.sv
module tb_collision_ci_ctrl;
  localparam int W  = 32;
  localparam int MW = 16;
  localparam int NE = 4;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_SEARCH = 3'd1, OP_RESULT = 3'd2, OP_STATUS = 3'd3;
  localparam logic [2:0] OP_DIGESTS = 3'd4, OP_ABORT = 3'd5, OP_RSTPTR = 3'd6, OP_NOP = 3'd7;

  logic             clk, reset, clk_en, start, done;
  logic [W-1:0]     dataa, datab, result, eng_target;
  logic [2:0]       n;
  logic [MW*W-1:0]  eng_msg;
  logic [NE-1:0]    eng_start, eng_abort, eng_digest, eng_hit;
  logic [NE*32-1:0] eng_counter;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  collision_ci_ctrl #(.WORD_SIZE(W), .MSG_WORDS(MW), .NUM_ENG(NE), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .done(done), .result(result),
    .eng_msg(eng_msg), .eng_target(eng_target), .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_digest(eng_digest), .eng_hit(eng_hit), .eng_counter(eng_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] msg_word(input int idx);
    return eng_msg[(MW-1-idx)*W +: W];
  endfunction

  // Called at posedge+1; drives one instruction, records its expected result.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string tag);
    start = 1'b1; clk_en = 1'b1; n = op; dataa = a; datab = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  // Scoreboard: each done pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        check(tag_q.pop_front(), 64'(result), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; clk_en = 1'b0; start = 1'b0; n = '0; dataa = '0; datab = '0;
    eng_digest = '0; eng_hit = '0; eng_counter = '0;
    #1;
    check("rst_done", 64'(done), 0);
    check("rst_result", 64'(result), 0);
    check("rst_target", 64'(eng_target), 0);
    check("rst_msg0", 64'(msg_word(0)), 0);
    check("rst_start", 64'(eng_start), 0);
    check("rst_abort", 64'(eng_abort), 0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    // Fill the buffer: pointer returns 2,4,...,14 then wraps to 0.
    for (int i = 0; i < 8; i++)
      issue(OP_LOAD, 32'h58585858 ^ W'(i), 32'h20202020 ^ W'(i), W'((2*i+2) % MW), "load_fill");
    check("msg_word0", 64'(msg_word(0)), 64'h58585858);
    check("msg_word1", 64'(msg_word(1)), 64'h20202020);
    check("msg_word14", 64'(msg_word(14)), 64'h5858585F);
    check("msg_word15", 64'(msg_word(15)), 64'h20202027);
    issue(OP_STATUS, 0, 0, 0, "status_idle");

    // clk_en low: nothing accepted, pointer stays at 0.
    start = 1'b1; clk_en = 1'b0; n = OP_LOAD;
    repeat (2) @(posedge clk);
    #1 start = 1'b0; clk_en = 1'b1;
    issue(OP_LOAD, 32'h11111111, 32'h22222222, 2, "load_after_clken0");
    issue(OP_RSTPTR, 0, 0, 0, "rstptr");
    issue(OP_LOAD, 32'h58585858, 32'h20202020, 2, "load_after_rstptr");
    issue(OP_NOP, 0, 0, 0, "nop");

    // Start a search.
    issue(OP_SEARCH, 5, 0, 0, "search1");
    check("start_pulse", 64'(eng_start), 64'hF);
    check("target", 64'(eng_target), 5);
    issue(OP_STATUS, 0, 0, 2, "status_search");
    check("start_one_cycle", 64'(eng_start), 0);
    issue(OP_LOAD, 1, 2, '1, "load_in_search");
    issue(OP_SEARCH, 6, 0, '1, "search_in_search");
    check("no_restart", 64'(eng_start), 0);
    check("target_kept", 64'(eng_target), 5);

    eng_digest = 4'b1011;
    repeat (10) @(posedge clk);
    #1 eng_digest = '0;
    issue(OP_DIGESTS, 0, 0, 30, "digests30");

    // Hit on engines 1 and 2: engine 1 wins; digest in hit cycle still counts.
    eng_counter = {32'h44, 32'hBB, 32'hAA, 32'h11};
    eng_hit = 4'b0110; eng_digest = 4'b0001;
    @(posedge clk); #1;
    eng_hit = '0; eng_digest = '0;
    check("abort_after_hit", 64'(eng_abort), 64'hD);
    issue(OP_STATUS, 0, 0, 32'h101, "status_found");
    check("abort_one_cycle", 64'(eng_abort), 0);
    issue(OP_RESULT, 0, 0, 32'hAA, "result_aa");
    issue(OP_DIGESTS, 0, 0, 31, "digests31");

    // Hits and digests are ignored outside SEARCH.
    eng_hit = 4'b0001; eng_digest = 4'b1111;
    @(posedge clk); #1;
    eng_hit = '0; eng_digest = '0;
    check("no_abort_found", 64'(eng_abort), 0);
    issue(OP_RESULT, 0, 0, 32'hAA, "result_kept");
    issue(OP_STATUS, 0, 0, 32'h101, "status_kept");
    issue(OP_DIGESTS, 0, 0, 31, "digests_frozen");

    // New search from FOUND; STATUS on the hit edge sees pre-edge state.
    issue(OP_SEARCH, 7, 0, 0, "search2");
    check("start_pulse2", 64'(eng_start), 64'hF);
    issue(OP_RESULT, 0, 0, 0, "result_cleared");
    eng_hit = 4'b0100;
    issue(OP_STATUS, 0, 0, 2, "status_pre_hit");
    eng_hit = '0;
    check("abort_after_hit2", 64'(eng_abort), 64'hB);
    issue(OP_STATUS, 0, 0, 32'h201, "status_found2");
    issue(OP_RESULT, 0, 0, 32'hBB, "result_bb");

    // ABORT from FOUND retains the winner counter.
    issue(OP_ABORT, 0, 0, 0, "abort_found");
    check("abort_all", 64'(eng_abort), 64'hF);
    issue(OP_STATUS, 0, 0, 0, "status_after_abort");
    issue(OP_RESULT, 0, 0, 32'hBB, "result_retained");

    // ABORT and hit on the same edge: abort wins, hit discarded.
    issue(OP_SEARCH, 9, 0, 0, "search3");
    issue(OP_RESULT, 0, 0, 0, "result_cleared3");
    eng_counter = {32'h44, 32'hBB, 32'hAA, 32'h77};
    eng_hit = 4'b0001;
    issue(OP_ABORT, 0, 0, 0, "abort_vs_hit");
    eng_hit = '0;
    check("abort_vs_hit_pulse", 64'(eng_abort), 64'hF);
    issue(OP_STATUS, 0, 0, 0, "status_abort_vs_hit");
    issue(OP_RESULT, 0, 0, 0, "result_hit_discarded");

    // Asynchronous reset mid-SEARCH while done is high.
    issue(OP_SEARCH, 5, 0, 0, "search4");
    issue(OP_LOAD, 1, 2, '1, "load_before_reset");
    clk_en = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("arst_done", 64'(done), 0);
    check("arst_result", 64'(result), 0);
    check("arst_target", 64'(eng_target), 0);
    check("arst_msg_nonzero_bits", 64'(|eng_msg), 0);
    check("arst_start", 64'(eng_start), 0);
    check("arst_abort", 64'(eng_abort), 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("no_abort_after_reset", 64'(eng_abort), 0);
    issue(OP_STATUS, 0, 0, 0, "status_after_reset");
    issue(OP_LOAD, 3, 4, 2, "load_after_reset");
    check("msg_after_reset", 64'(msg_word(0)), 3);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
